// File: rtl/fifo_wrptr_ctrl.sv
// Write-side pointer and flag controller for an asynchronous FIFO.
// Holds the binary write pointer and publishes it in Gray code to the read
// domain. Full, almost-full and occupancy are computed against the read
// pointer, which has already been synchronized into clk.
module fifo_wrptr_ctrl #(
  parameter int ADDRWIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 srstn,
  input  logic                 we,
  input  logic [ADDRWIDTH:0]   rd_ptr_gray_sync,
  output logic [ADDRWIDTH:0]   wr_ptr_gray,
  output logic [ADDRWIDTH-1:0] mem_waddr,
  output logic                 mem_we,
  output logic                 full,
  output logic                 afull,
  output logic                 wr_ack,
  output logic                 overflow,
  output logic [ADDRWIDTH:0]   wr_cnt
);

  localparam int PW = ADDRWIDTH + 1;
  // The two pointer MSBs differ exactly when the write side is one lap ahead.
  localparam logic [PW-1:0] FULL_FLIP = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] AFULL_T   = PW'(AFULL_THRESH);

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] wr_gray_next;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] occ_next;
  logic          accept;

  // Writes are never accepted while either reset is asserted.
  assign accept       = we & ~full & srstn & arstn;
  assign mem_we       = accept;
  assign mem_waddr    = wr_bin[ADDRWIDTH-1:0];
  assign wr_bin_next  = wr_bin + {{ADDRWIDTH{1'b0}}, accept};
  assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
  assign occ_next     = wr_bin_next - rd_bin;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < PW; i++) begin
      rd_bin[i] = ^(rd_ptr_gray_sync >> i);
    end
  end

  // Pointer, flag and pulse registers, re-evaluated every cycle.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      afull       <= 1'b0;
      wr_ack      <= 1'b0;
      overflow    <= 1'b0;
      wr_cnt      <= '0;
    end else if (!srstn) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      afull       <= 1'b0;
      wr_ack      <= 1'b0;
      overflow    <= 1'b0;
      wr_cnt      <= '0;
    end else begin
      wr_bin      <= wr_bin_next;
      wr_ptr_gray <= wr_gray_next;
      full        <= (wr_gray_next == (rd_ptr_gray_sync ^ FULL_FLIP));
      afull       <= (occ_next >= AFULL_T);
      wr_ack      <= accept;
      overflow    <= we & full;
      wr_cnt      <= occ_next;
    end
  end

endmodule

// File: doc/fifo_wrptr_ctrl.md
FIFO_WRPTR_CTRL -- requirements
Module: fifo_wrptr_ctrl

Interface
REQ-001 The block SHALL have parameter ADDRWIDTH, default 3, giving RAM address width; FIFO depth is 2^ADDRWIDTH.
REQ-002 The block SHALL have parameter AFULL_THRESH, default 6, giving the almost-full occupancy threshold, legal range 1..2^ADDRWIDTH.
REQ-003 The block SHALL have port clk, input, 1, write-domain clock, rising edge.
REQ-004 The block SHALL have port arstn, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port srstn, input, 1, synchronous reset, active-low.
REQ-006 The block SHALL have port we, input, 1, write request from the producer.
REQ-007 The block SHALL have port rd_ptr_gray_sync, input, ADDRWIDTH+1, Gray-coded read pointer already synchronized into clk.
REQ-008 The block SHALL have port wr_ptr_gray, output, ADDRWIDTH+1, registered Gray-coded write pointer, feeding the read-domain synchronizer.
REQ-009 The block SHALL have port mem_waddr, output, ADDRWIDTH, RAM write address.
REQ-010 The block SHALL have port mem_we, output, 1, RAM write strobe.
REQ-011 The block SHALL have port full, output, 1, registered full flag.
REQ-012 The block SHALL have port afull, output, 1, registered almost-full flag.
REQ-013 The block SHALL have port wr_ack, output, 1, one-cycle acknowledge of an accepted write.
REQ-014 The block SHALL have port overflow, output, 1, one-cycle pulse for a write rejected while full.
REQ-015 The block SHALL have port wr_cnt, output, ADDRWIDTH+1, registered occupancy seen from the write side.

Function
REQ-016 The block SHALL hold an internal binary write pointer wr_bin, ADDRWIDTH+1 bits, wrapping from 2^(ADDRWIDTH+1)-1 to 0.
REQ-017 The block SHALL accept a write when we=1 and full=0; accept = we & ~full is combinational.
REQ-018 The block SHALL drive mem_we = accept combinationally in the same cycle, with mem_waddr = wr_bin[ADDRWIDTH-1:0].
REQ-019 On an accept edge, the block SHALL set wr_bin to wr_bin+1; otherwise wr_bin SHALL hold.
REQ-020 The block SHALL register wr_ptr_gray = wr_bin_next ^ (wr_bin_next >> 1), so it changes by exactly one bit per accept.
REQ-021 The block SHALL convert rd_ptr_gray_sync to binary rd_bin combinationally by prefix XOR from the MSB.
REQ-022 The block SHALL register full = 1 when the Gray of wr_bin_next equals rd_ptr_gray_sync with its two MSBs inverted and all other bits equal; otherwise full = 0.
REQ-023 The block SHALL register wr_cnt = wr_bin_next - rd_bin, modulo 2^(ADDRWIDTH+1).
REQ-024 The block SHALL register afull = 1 when (wr_bin_next - rd_bin) >= AFULL_THRESH; otherwise afull = 0.
REQ-025 The block SHALL register wr_ack = accept, a one-cycle pulse on the edge following the accepted cycle.
REQ-026 The block SHALL register overflow = we & full, a one-cycle pulse with no pointer or RAM change.
REQ-027 Flags SHALL be re-evaluated every cycle, so a read-pointer advance with no write clears full and updates wr_cnt one cycle after rd_ptr_gray_sync changes.
REQ-028 For a write accepted in the cycle that the read pointer advances, the block SHALL use the sampled rd_ptr_gray_sync for that cycle; full SHALL remain conservative, never asserting late.

Reset
REQ-029 On arstn=0, asynchronously, the block SHALL clear wr_bin, wr_ptr_gray, full, afull, wr_ack, overflow and wr_cnt to 0.
REQ-030 On srstn=0 at a rising edge, the block SHALL apply the same clears synchronously; we SHALL be ignored that cycle.
REQ-031 While either reset is active, mem_we SHALL be 0.

Verification (ADDRWIDTH=3, AFULL_THRESH=6, rd_ptr_gray_sync=0 unless stated)
REQ-032 Eight back-to-back writes -> mem_waddr 0..7 with mem_we=1 each cycle; afull=1 after the 6th accept; full=1 after the 8th accept; wr_ptr_gray=4'b1100; wr_cnt=8.
REQ-033 A 9th write while full -> mem_we=0, overflow=1 for one cycle, wr_ack=0, wr_ptr_gray unchanged.
REQ-034 When full, driving rd_ptr_gray_sync=4'b0001 -> next cycle full=0, wr_cnt=7, afull=1.
REQ-035 Sixteen writes with the read pointer tracking one write behind -> wr_bin wraps to 0, wr_ptr_gray=4'b0000, full never asserted, wr_cnt=1 or 0 throughout.
REQ-036 After 5 writes, srstn=0 for one cycle while we=1 -> next edge all outputs are 0 and no mem_we occurs; arstn pulsed mid-write -> outputs clear immediately without a clock.
